// File: rtl/fifo_read_controller.sv
// Read-domain controller for the I2C master async FIFO: read pointer ownership,
// empty/level derivation, synchronous-RAM read sequencing and round-robin
// arbitration between the transmit engine (req 0) and the register path (req 1).
module fifo_read_controller #(
  parameter int addr_size = 3,
  parameter int data_size = 8
) (
  input  logic                 read_clock_i,
  input  logic                 read_reset_n_i,
  input  logic [addr_size:0]   write_to_read_pointer_i,
  input  logic [1:0]           rd_req_i,
  input  logic                 flush_i,
  input  logic [data_size-1:0] mem_read_data_i,
  output logic [1:0]           rd_gnt_o,
  output logic [data_size-1:0] rd_data_o,
  output logic                 rd_data_valid_o,
  output logic                 mem_rd_en_o,
  output logic [addr_size-1:0] mem_read_addr_o,
  output logic [addr_size:0]   read_pointer_o,
  output logic                 empty_o,
  output logic [addr_size:0]   level_o
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [addr_size:0]     r_rbin;
  logic [addr_size:0]     r_rptr;
  logic [addr_size:0]     r_level;
  logic [1:0]             r_gnt;
  logic [data_size-1:0]   r_data;
  logic                   r_valid;
  logic                   r_last_gnt;
  logic [addr_size:0]     w_wbin;
  logic [addr_size:0]     w_rbin_inc;
  logic                   w_empty;
  logic                   w_flush;
  logic                   w_take;
  logic                   w_winner;

  // Gray-to-binary of the synchronized write pointer: bit i is the XOR of all Gray bits at or above i
  always_comb begin
    w_wbin = '0;
    for (int unsigned i = 0; i <= addr_size; i++) begin
      w_wbin[i] = ^(write_to_read_pointer_i >> i);
    end
  end

  assign w_rbin_inc = r_rbin + 1'b1;
  assign w_empty    = (r_rptr == write_to_read_pointer_i);

  // Next-state, flush/grant decisions and round-robin winner selection
  always_comb begin
    w_state_next = r_state;
    w_flush      = 1'b0;
    w_take       = 1'b0;
    w_winner     = 1'b0;
    unique case (rd_req_i)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_last_gnt;
      default: w_winner = 1'b0;
    endcase
    unique case (r_state)
      IDLE: begin
        if (flush_i) begin
          w_flush = 1'b1;
        end else if (!w_empty && (rd_req_i != 2'b00)) begin
          w_take       = 1'b1;
          w_state_next = FETCH;
        end
      end
      FETCH:   w_state_next = WAIT;
      WAIT:    w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
    if (!read_reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pointer, level, grant and read-data registers
  always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
    if (!read_reset_n_i) begin
      r_rbin     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_gnt      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last_gnt <= 1'b1;
    end else begin
      r_level <= w_wbin - r_rbin;
      if (w_flush) begin
        r_rbin <= w_wbin;
        r_rptr <= w_wbin ^ (w_wbin >> 1);
      end else if (w_take) begin
        r_gnt      <= w_winner ? 2'b10 : 2'b01;
        r_last_gnt <= w_winner;
      end
      if (r_state == WAIT) begin
        r_data  <= mem_read_data_i;
        r_valid <= 1'b1;
        r_rbin  <= w_rbin_inc;
        r_rptr  <= w_rbin_inc ^ (w_rbin_inc >> 1);
      end
      if (r_state == DONE) begin
        r_valid <= 1'b0;
        r_gnt   <= '0;
      end
    end
  end

  assign mem_rd_en_o     = (r_state == FETCH);
  assign mem_read_addr_o = r_rbin[addr_size-1:0];
  assign read_pointer_o  = r_rptr;
  assign empty_o         = w_empty;
  assign level_o         = r_level;
  assign rd_gnt_o        = r_gnt;
  assign rd_data_o       = r_data;
  assign rd_data_valid_o = r_valid;

endmodule

// File: tb/tb_fifo_read_controller.sv
// Self-checking bench for fifo_read_controller: directed scenarios plus a
// randomized run against a transaction-level model (pointer arithmetic, RAM array).
module tb_fifo_read_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] wptr = '0;
  logic [1:0] req = '0;
  logic       flush = 1'b0;
  logic [7:0] ram_q = '0;
  logic [1:0] gnt;
  logic [7:0] data;
  logic       valid;
  logic       mem_en;
  logic [2:0] addr;
  logic [3:0] rptr;
  logic       empty;
  logic [3:0] level;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Reference model state
  logic [3:0] m_wbin = '0;
  logic [3:0] m_rbin = '0;
  logic       m_last = 1'b1;
  logic [7:0] mem [8];

  fifo_read_controller #(.addr_size(3), .data_size(8)) dut (
    .read_clock_i(clk), .read_reset_n_i(rst_n), .write_to_read_pointer_i(wptr),
    .rd_req_i(req), .flush_i(flush), .mem_read_data_i(ram_q),
    .rd_gnt_o(gnt), .rd_data_o(data), .rd_data_valid_o(valid), .mem_rd_en_o(mem_en),
    .mem_read_addr_o(addr), .read_pointer_o(rptr), .empty_o(empty), .level_o(level)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data only meaningful the cycle after an enable, garbage otherwise
  always @(posedge clk) begin
    if (mem_en) ram_q <= mem[addr];
    else        ram_q <= 8'($urandom);
  end

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wbin(input logic [3:0] v);
    m_wbin = v;
    wptr = gray(v);
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[m_wbin[2:0]] = d;
    set_wbin(m_wbin + 4'd1);
  endtask

  task automatic do_reset;
    req = '0; flush = 1'b0; rst_n = 1'b0;
    set_wbin(4'd0);
    tick;
    @(negedge clk) rst_n = 1'b1;
    m_rbin = '0; m_last = 1'b1;
  endtask

  // One full read transaction from IDLE; expectations come from the model
  task automatic do_read(input logic [1:0] r, input bit hold, output logic [1:0] got_gnt);
    logic       win;
    logic [1:0] eg;
    logic [7:0] ed;
    logic [3:0] el;
    win = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : ~m_last;
    eg  = win ? 2'b10 : 2'b01;
    ed  = mem[m_rbin[2:0]];
    el  = m_wbin - m_rbin;
    req = r;
    tick;
    got_gnt = gnt;
    n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL read_gnt: got %b expected %b", gnt, eg); end
    n_chk++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL read_memen_e1: got %b expected 1", mem_en); end
    n_chk++; if (addr !== m_rbin[2:0]) begin n_fail++; $display("FAIL read_addr: got %0d expected %0d", addr, m_rbin[2:0]); end
    n_chk++; if (level !== el) begin n_fail++; $display("FAIL read_level: got %0d expected %0d", level, el); end
    if (!hold) req = '0;
    tick;
    n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL read_memen_e2: got %b expected 0", mem_en); end
    n_chk++; if (addr !== m_rbin[2:0]) begin n_fail++; $display("FAIL read_addr_e2: got %0d expected %0d", addr, m_rbin[2:0]); end
    tick;
    m_rbin = m_rbin + 4'd1;
    m_last = win;
    n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL read_valid: got %b expected 1", valid); end
    n_chk++; if (data !== ed) begin n_fail++; $display("FAIL read_data: got %h expected %h", data, ed); end
    n_chk++; if (rptr !== gray(m_rbin)) begin n_fail++; $display("FAIL read_rptr: got %b expected %b", rptr, gray(m_rbin)); end
    n_chk++; if (empty !== (m_wbin == m_rbin)) begin n_fail++; $display("FAIL read_empty: got %b expected %b", empty, m_wbin == m_rbin); end
    n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL read_gnt_e3: got %b expected %b", gnt, eg); end
    tick;
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL read_valid_e4: got %b expected 0", valid); end
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL read_gnt_e4: got %b expected 00", gnt); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; set_wbin(4'd0);
    tick; tick;
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b expected 00", gnt); end
    n_chk++; if (data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h expected 00", data); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", valid); end
    n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_memen: got %b expected 0", mem_en); end
    n_chk++; if (addr !== 3'd0) begin n_fail++; $display("FAIL rst_addr: got %0d expected 0", addr); end
    n_chk++; if (rptr !== 4'd0) begin n_fail++; $display("FAIL rst_rptr: got %b expected 0000", rptr); end
    n_chk++; if (level !== 4'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", level); end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b expected 1", empty); end
    @(negedge clk) rst_n = 1'b1;
    m_rbin = '0; m_last = 1'b1;
  endtask

  task automatic test_single_read;
    logic [1:0] g;
    do_reset;
    mem[0] = 8'hA5;
    set_wbin(4'd1);
    do_read(2'b01, 1'b0, g);
    n_chk++; if (rptr !== 4'b0001) begin n_fail++; $display("FAIL single_rptr: got %b expected 0001", rptr); end
    n_chk++; if (data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", data); end
    n_chk++; if (level !== 4'd0) begin n_fail++; $display("FAIL single_level: got %0d expected 0", level); end
  endtask

  task automatic test_arbitration;
    logic [1:0] g;
    logic [1:0] exp_seq [3];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
    do_reset;
    for (int i = 0; i < 3; i++) push_word(8'($urandom));
    for (int i = 0; i < 3; i++) begin
      do_read(2'b11, 1'b1, g);
      n_chk++; if (g !== exp_seq[i]) begin n_fail++; $display("FAIL arb_seq%0d: got %b expected %b", i, g, exp_seq[i]); end
    end
    tick;
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL arb_drained: got %b expected 00", gnt); end
    req = '0;
  endtask

  task automatic test_wraparound;
    logic [1:0] g;
    do_reset;
    set_wbin(4'd14);
    n_chk++; if (wptr !== 4'b1001) begin n_fail++; $display("FAIL wrap_gray14: got %b expected 1001", wptr); end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    m_rbin = m_wbin;
    n_chk++; if (rptr !== 4'b1001) begin n_fail++; $display("FAIL wrap_flush_rptr: got %b expected 1001", rptr); end
    tick;
    mem[6] = 8'($urandom); mem[7] = 8'($urandom);
    set_wbin(4'd0);
    tick;
    n_chk++; if (level !== 4'd2) begin n_fail++; $display("FAIL wrap_level: got %0d expected 2", level); end
    do_read(2'b01, 1'b0, g);
    n_chk++; if (rptr !== 4'b1000) begin n_fail++; $display("FAIL wrap_rptr1: got %b expected 1000", rptr); end
    do_read(2'b10, 1'b0, g);
    n_chk++; if (rptr !== 4'b0000) begin n_fail++; $display("FAIL wrap_rptr2: got %b expected 0000", rptr); end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  task automatic test_flush_timing;
    logic [7:0] d;
    do_reset;
    d = 8'($urandom);
    push_word(d); push_word(8'($urandom));
    req = 2'b01;
    tick;
    n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL flush_e1_gnt: got %b expected 01", gnt); end
    flush = 1'b1;
    tick; tick;
    n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL flush_ignored_valid: got %b expected 1", valid); end
    n_chk++; if (data !== d) begin n_fail++; $display("FAIL flush_ignored_data: got %h expected %h", data, d); end
    n_chk++; if (rptr !== 4'b0001) begin n_fail++; $display("FAIL flush_ignored_rptr: got %b expected 0001", rptr); end
    tick; tick;
    n_chk++; if (rptr !== gray(m_wbin)) begin n_fail++; $display("FAIL flush_rptr: got %b expected %b", rptr, gray(m_wbin)); end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b expected 1", empty); end
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL flush_no_gnt: got %b expected 00", gnt); end
    tick;
    n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL flush_no_fetch: got %b expected 0", mem_en); end
    n_chk++; if (level !== 4'd0) begin n_fail++; $display("FAIL flush_level: got %0d expected 0", level); end
    flush = 1'b0; req = '0;
    m_rbin = m_wbin; m_last = 1'b0;
  endtask

  task automatic test_empty_guard;
    do_reset;
    req = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick;
      n_chk++; if (gnt !== 2'b00 || mem_en !== 1'b0) begin n_fail++; $display("FAIL empty_guard%0d: got gnt=%b en=%b expected 00/0", i, gnt, mem_en); end
    end
    push_word(8'($urandom));
    tick;
    n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL empty_release_gnt: got %b expected 01", gnt); end
    req = '0;
    tick; tick; tick;
    m_rbin = 4'd1; m_last = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    do_reset;
    push_word(8'($urandom));
    req = 2'b01;
    tick;
    req = '0;
    tick;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL midrst_gnt: got %b expected 00", gnt); end
    n_chk++; if (rptr !== 4'd0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got rptr=%b en=%b expected 0000/0", rptr, mem_en); end
    @(negedge clk) rst_n = 1'b1;
    m_rbin = '0; m_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_valid%0d: got %b expected 0", i, valid); end
    end
  endtask

  task automatic test_random;
    logic [1:0] g;
    int unsigned room;
    do_reset;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        req = 2'($urandom_range(0, 3));
        flush = 1'b1;
        tick;
        flush = 1'b0; req = '0;
        m_rbin = m_wbin;
        n_chk++; if (rptr !== gray(m_wbin) || empty !== 1'b1 || gnt !== 2'b00) begin n_fail++; $display("FAIL rnd_flush: got rptr=%b empty=%b gnt=%b expected %b/1/00", rptr, empty, gnt, gray(m_wbin)); end
      end else begin
        room = 8 - int'(4'(m_wbin - m_rbin));
        for (int k = $urandom_range(0, room); k > 0; k--) push_word(8'($urandom));
        if (m_wbin == m_rbin) begin
          req = 2'($urandom_range(1, 3));
          tick;
          req = '0;
          n_chk++; if (gnt !== 2'b00 || empty !== 1'b1 || level !== 4'd0) begin n_fail++; $display("FAIL rnd_empty: got gnt=%b empty=%b level=%0d expected 00/1/0", gnt, empty, level); end
        end else begin
          do_read(2'($urandom_range(1, 3)), 1'b0, g);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    test_reset;
    test_single_read;
    test_arbitration;
    test_wraparound;
    test_flush_timing;
    test_empty_guard;
    test_reset_mid_wait;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_read_controller.md
# fifo_read_controller

Read-domain controller for the I2C master's asynchronous FIFO. It owns the read pointer and derives empty and fill level against the write pointer, which arrives already synchronized into the read domain. It sequences synchronous-RAM reads and arbitrates FIFO access round-robin between two requesters: requester 0 is the I2C transmit engine and requester 1 is the register/drain path. Its Gray read pointer output feeds the read-to-write synchronizer.

## Interface
- addr_size, 3, FIFO depth is 2^addr_size; pointers are addr_size+1 bits
- data_size, 8, FIFO word width
- read_clock_i  in  1  read-domain clock
- read_reset_n_i  in  1  reset read_reset_n_i, asynchronous, active-low; clock read_clock_i
- write_to_read_pointer_i  in  addr_size+1  Gray write pointer, already synchronized to read_clock_i
- rd_req_i  in  2  per-requester read request, level, held until grant
- flush_i  in  1  discard all stored words, level
- mem_read_data_i  in  data_size  sync RAM output, valid the cycle after a mem_rd_en_o cycle
- rd_gnt_o  out  2  one-hot grant, registered
- rd_data_o  out  data_size  read word, registered
- rd_data_valid_o  out  1  one-cycle strobe, rd_data_o valid for granted requester
- mem_rd_en_o  out  1  RAM read enable
- mem_read_addr_o  out  addr_size  RAM read address, equal to rbin[addr_size-1:0]
- read_pointer_o  out  addr_size+1  Gray read pointer, registered
- empty_o  out  1  FIFO empty
- level_o  out  addr_size+1  words stored, registered

## Operation
- Internal state: binary pointer rbin (addr_size+1 bits), read_pointer_o = rbin ^ (rbin>>1), registered together with rbin.
- wbin = Gray-to-binary of write_to_read_pointer_i.
- empty_o = (read_pointer_o == write_to_read_pointer_i), combinational from registered/synchronized values.
- level_o <= (wbin - rbin) mod 2^(addr_size+1) every cycle.
- FSM states: IDLE, FETCH, WAIT, DONE.
  - IDLE: if flush_i, then rbin <= wbin; flush has priority over requests and no grant is issued that cycle.
  - IDLE: else, if !empty_o and rd_req_i != 0, select a winner and go to FETCH with rd_gnt_o <= winner.
  - FETCH: mem_rd_en_o=1 for exactly this cycle; go to WAIT.
  - WAIT: go to DONE; rd_data_o <= mem_read_data_i; rd_data_valid_o <= 1; rbin <= rbin+1 (wraps 2^(addr_size+1)-1 -> 0).
  - DONE: rd_data_valid_o <= 0; rd_gnt_o <= 0; go to IDLE.
- Arbitration: last_gnt register, reset value 1.
  - Single requester wins.
  - Both requesting: winner = the requester not equal to last_gnt. last_gnt updates on every grant.
- flush_i outside IDLE is ignored; the caller holds it until serviced. rd_req_i changes outside IDLE are ignored. A grant is never revoked.
- Write pointer advancing during a read only changes level_o/empty_o; the in-flight read is unaffected.
- Reset, including mid-operation: state IDLE, rbin=0, read_pointer_o=0, rd_gnt_o=0, rd_data_o=0, rd_data_valid_o=0, mem_rd_en_o=0, level_o=0, last_gnt=1. empty_o=1 while the write pointer is 0.

## Timing
- E1 = edge at which IDLE samples !empty_o and a request. The grant and mem_rd_en_o are visible after E1.
- RAM samples mem_read_addr_o at E2.
- rd_data_valid_o, rd_data_o and the incremented read_pointer_o are visible after E3 and stay visible for one cycle. rd_gnt_o drops after E4.
- Request-to-data latency is 3 cycles. Throughput is 1 word per 4 cycles, since the earliest next grant is at E5.
- mem_read_addr_o is stable from before E1 through E3.
- Flush in IDLE: read_pointer_o equals write_to_read_pointer_i after the edge; empty_o=1; level_o=0 one cycle later.

## Test plan
- Reset: hold reset with write pointer 0 -> all outputs 0, empty_o=1. Assert reset mid-WAIT -> rd_gnt_o=0 immediately and no rd_data_valid_o follows.
- Single read: write pointer Gray 0001, rd_req_i=01, mem_read_data_i=0xA5 after E2 -> rd_gnt_o=01 and mem_rd_en_o=1 after E1, mem_read_addr_o=0. After E3: rd_data_o=0xA5, rd_data_valid_o=1 for one cycle, read_pointer_o=0001, empty_o=1. level_o=0 one cycle later.
- Arbitration: 3 words stored, rd_req_i=11 held -> grants 01, 10, 01 in successive transactions, spaced 4 cycles apart.
- Wrap-around: flush with write pointer Gray 1001 (bin 14), then write pointer Gray 0000 (bin 0) -> level_o=2. Two reads use addresses 6 and 7, with read_pointer_o 1000 then 0000, then empty_o=1.
- Flush timing: flush_i asserted during FETCH -> ignored and the read completes. Flush held into IDLE -> read_pointer_o = write pointer, empty_o=1, no grant despite pending rd_req_i.
- Empty guard: rd_req_i=01 with empty_o=1 for 10 cycles -> no grant and mem_rd_en_o=0. A write pointer increment then produces a grant at the next edge.
